// File: rtl/mccpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, instruction
// classes, opcode/funct values, ALU operation codes and datapath select codes.
package mccpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_RS  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC  = 2'd2;

endpackage

// File: rtl/mccpu_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in, strobes
// and selects out. master = controller, slave = datapath.
interface mccpu_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       ir_wr;
  logic       dmem_wena;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wb_sel;
  logic       alu_src_b;
  logic       ext_sign;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output pc_wr, pc_src, ir_wr, dmem_wena, reg_wr, reg_dst, wb_sel,
           alu_src_b, ext_sign, alu_ctrl, state, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pc_wr, pc_src, ir_wr, dmem_wena, reg_wr, reg_dst, wb_sel,
           alu_src_b, ext_sign, alu_ctrl, state, illegal
  );
endinterface

// File: rtl/mccpu_decode.sv
// Combinational instruction decoder: op/funct -> instruction class, ALU code,
// immediate extension mode and legality.
module mccpu_decode
  import mccpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic [3:0] alu_ctrl_o,
  output logic       ext_sign_o,
  output logic       legal_o
);

  always_comb begin
    cls_o      = C_ILL;
    alu_ctrl_o = ALU_ADD;
    ext_sign_o = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        cls_o = C_RALU;
        case (funct_i)
          F_ADD, F_ADDU: alu_ctrl_o = ALU_ADD;
          F_SUB, F_SUBU: alu_ctrl_o = ALU_SUB;
          F_AND:         alu_ctrl_o = ALU_AND;
          F_OR:          alu_ctrl_o = ALU_OR;
          F_XOR:         alu_ctrl_o = ALU_XOR;
          F_NOR:         alu_ctrl_o = ALU_NOR;
          F_SLT:         alu_ctrl_o = ALU_SLT;
          F_SLTU:        alu_ctrl_o = ALU_SLTU;
          F_SLL:         alu_ctrl_o = ALU_SLL;
          F_SRL:         alu_ctrl_o = ALU_SRL;
          F_SRA:         alu_ctrl_o = ALU_SRA;
          F_JR:          cls_o      = C_JR;
          default:       cls_o      = C_ILL;
        endcase
      end
      OP_J:     cls_o = C_J;
      OP_JAL:   cls_o = C_JAL;
      OP_BEQ:   begin cls_o = C_BEQ;  alu_ctrl_o = ALU_SUB;  end
      OP_BNE:   begin cls_o = C_BNE;  alu_ctrl_o = ALU_SUB;  end
      OP_ADDI,
      OP_ADDIU: begin cls_o = C_IALU; alu_ctrl_o = ALU_ADD;  end
      OP_SLTI:  begin cls_o = C_IALU; alu_ctrl_o = ALU_SLT;  end
      OP_SLTIU: begin cls_o = C_IALU; alu_ctrl_o = ALU_SLTU; end
      // Logical immediates are zero-extended.
      OP_ANDI:  begin cls_o = C_IALU; alu_ctrl_o = ALU_AND; ext_sign_o = 1'b0; end
      OP_ORI:   begin cls_o = C_IALU; alu_ctrl_o = ALU_OR;  ext_sign_o = 1'b0; end
      OP_XORI:  begin cls_o = C_IALU; alu_ctrl_o = ALU_XOR; ext_sign_o = 1'b0; end
      OP_LUI:   begin cls_o = C_IALU; alu_ctrl_o = ALU_LUI;  end
      OP_LW:    cls_o = C_LW;
      OP_SW:    cls_o = C_SW;
      default:  cls_o = C_ILL;
    endcase
    legal_o = (cls_o != C_ILL);
  end

endmodule

// File: rtl/mccpu_control.sv
// Multi-cycle CPU control FSM with MEM wait counter.
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | latch decode; jumps complete here
// EXEC   | ALU op / address calc / branch resolve
// MEM    | data access, MEM_WAIT+1 cycles
// WB     | register file write-back
// TRAP   | unsupported instruction, held until reset
module mccpu_control
  import mccpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic     clock,
  input  logic     reset,
  mccpu_if.master  ctl
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  iclass_e    dec_cls;
  logic [3:0] dec_alu;
  logic       dec_ext;
  logic       dec_legal;

  state_e     state_q;
  iclass_e    cls_q;
  logic [3:0] alu_q;
  logic       ext_q;
  logic [2:0] wait_q;
  logic       mem_last;

  mccpu_decode u_decode (
    .op_i       (ctl.op),
    .funct_i    (ctl.funct),
    .cls_o      (dec_cls),
    .alu_ctrl_o (dec_alu),
    .ext_sign_o (dec_ext),
    .legal_o    (dec_legal)
  );

  assign mem_last = (wait_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 3'd0;
      cls_q   <= C_RALU;
      alu_q   <= ALU_ADD;
      ext_q   <= 1'b1;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          cls_q  <= dec_cls;
          alu_q  <= dec_alu;
          ext_q  <= dec_ext;
          wait_q <= 3'd0;
          if (!dec_legal)
            state_q <= S_TRAP;
          else if (dec_cls == C_J || dec_cls == C_JAL || dec_cls == C_JR)
            state_q <= S_FETCH;
          else
            state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (cls_q)
            C_BEQ, C_BNE: state_q <= S_FETCH;
            C_LW, C_SW: begin
              state_q <= S_MEM;
              wait_q  <= 3'd0;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_last)
            state_q <= (cls_q == C_LW) ? S_WB : S_FETCH;
          else
            wait_q <= wait_q + 3'd1;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Reset gates everything combinationally so a pending write is never seen.
  always_comb begin
    ctl.pc_wr     = 1'b0;
    ctl.pc_src    = PCSRC_SEQ;
    ctl.ir_wr     = 1'b0;
    ctl.dmem_wena = 1'b0;
    ctl.reg_wr    = 1'b0;
    ctl.reg_dst   = REGDST_RT;
    ctl.wb_sel    = WBSEL_ALU;
    ctl.alu_src_b = 1'b0;
    ctl.ext_sign  = 1'b0;
    ctl.alu_ctrl  = ALU_ADD;
    ctl.illegal   = 1'b0;
    ctl.state     = 3'd0;
    if (!reset) begin
      ctl.state = state_q;
      case (state_q)
        S_FETCH: begin
          ctl.ir_wr = 1'b1;
          ctl.pc_wr = 1'b1;
        end
        S_DECODE: begin
          case (dec_cls)
            C_J: begin
              ctl.pc_wr  = 1'b1;
              ctl.pc_src = PCSRC_JMP;
            end
            C_JAL: begin
              ctl.pc_wr   = 1'b1;
              ctl.pc_src  = PCSRC_JMP;
              ctl.reg_wr  = 1'b1;
              ctl.reg_dst = REGDST_RA;
              ctl.wb_sel  = WBSEL_PC;
            end
            C_JR: begin
              ctl.pc_wr  = 1'b1;
              ctl.pc_src = PCSRC_RS;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          ctl.alu_ctrl  = alu_q;
          ctl.ext_sign  = ext_q;
          ctl.alu_src_b = (cls_q == C_IALU) || (cls_q == C_LW) || (cls_q == C_SW);
          if (cls_q == C_BEQ || cls_q == C_BNE) begin
            ctl.pc_src = PCSRC_BR;
            ctl.pc_wr  = (cls_q == C_BEQ) ? ctl.zero : !ctl.zero;
          end
        end
        S_MEM: ctl.dmem_wena = (cls_q == C_SW) && mem_last;
        S_WB: begin
          ctl.reg_wr = 1'b1;
          case (cls_q)
            C_LW: begin
              ctl.reg_dst = REGDST_RT;
              ctl.wb_sel  = WBSEL_MEM;
            end
            C_IALU:  ctl.reg_dst = REGDST_RT;
            default: ctl.reg_dst = REGDST_RD;
          endcase
        end
        S_TRAP:  ctl.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mccpu_control.md
MCCPU_CONTROL -- requirements
Module: mccpu_control

Interface
REQ-001 Parameter MEM_WAIT, default 0, number of extra cycles spent in MEM before the access completes (range 0..7).
REQ-002 Design SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 op  input  6  IR[31:26] from the instruction register.
REQ-006 funct  input  6  IR[5:0].
REQ-007 zero  input  1  ALU zero flag (rs==rt compare result in EXEC).
REQ-008 pc_wr  output  1  PC load strobe.
REQ-009 pc_src  output  2  0=PC+4, 1=branch target, 2=jump {PC[31:28],IR[25:0],00}, 3=rs.
REQ-010 ir_wr  output  1  IR load strobe.
REQ-011 dmem_wena  output  1  data memory write enable.
REQ-012 reg_wr  output  1  register file write strobe.
REQ-013 reg_dst  output  2  0=rt, 1=rd, 2=$31.
REQ-014 wb_sel  output  2  0=ALU result register, 1=memory data register, 2=PC (PC+4 link).
REQ-015 alu_src_b  output  1  0=rt data, 1=extended immediate.
REQ-016 ext_sign  output  1  1=sign-extend immediate, 0=zero-extend.
REQ-017 alu_ctrl  output  4  ALU operation code (package constants).
REQ-018 state  output  3  current FSM state, for debug.
REQ-019 illegal  output  1  high while in TRAP.

Function
REQ-020 FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; outputs SHALL be Moore (state + registered decode), except pc_wr in EXEC for branches, which is qualified by zero.
REQ-021 FETCH: ir_wr=1, pc_wr=1, pc_src=0; next DECODE.
REQ-022 DECODE: j -> pc_wr=1, pc_src=2, next FETCH; jal -> additionally reg_wr=1, reg_dst=2, wb_sel=2; jr (op 0, funct 08) -> pc_wr=1, pc_src=3, next FETCH; unsupported op/funct -> TRAP; otherwise next EXEC.
REQ-023 EXEC: beq -> pc_wr=zero, bne -> pc_wr=!zero, pc_src=1, next FETCH; lw/sw -> alu_ctrl=ADD, alu_src_b=1, ext_sign=1, next MEM; R-type/immediate ALU -> next WB.
REQ-024 MEM SHALL last exactly MEM_WAIT+1 cycles via a wait counter cleared on entry; sw asserts dmem_wena only in the final MEM cycle then goes to FETCH; lw goes to WB after the final cycle.
REQ-025 WB: reg_wr=1; lw -> reg_dst=0, wb_sel=1; immediate ALU -> reg_dst=0, wb_sel=0; R-type -> reg_dst=1, wb_sel=0; next FETCH.
REQ-026 Cycle counts at MEM_WAIT=0: j/jal/jr 2, beq/bne 3, R-type/immediate/sw 4, lw 5.
REQ-027 Supported: R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr; addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne, j, jal.
REQ-028 ext_sign=0 for andi/ori/xori, 1 otherwise; add/addu and addi/addiu SHALL map to the same ALU code (no overflow trap).
REQ-029 TRAP SHALL hold with illegal=1 and all strobes low until reset.
REQ-030 At most one of pc_wr, dmem_wena, reg_wr, ir_wr pairs SHALL fire together, except FETCH (ir_wr+pc_wr) and jal (pc_wr+reg_wr).

Reset
REQ-031 While reset is high at a clock edge, next state SHALL be FETCH, the wait counter 0, illegal 0.
REQ-032 While reset is high, all strobes (pc_wr, ir_wr, dmem_wena, reg_wr) SHALL be forced 0 combinationally, and selects, alu_ctrl and state SHALL read 0; reset mid-MEM SHALL suppress the pending write.

Structure
REQ-033 Package mccpu_pkg SHALL hold the state encoding, opcode/funct constants, ALU codes (ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11) and pc_src/reg_dst/wb_sel codes.
REQ-034 One combinational sub-module mccpu_decode SHALL map op/funct to instruction class, alu_ctrl, ext_sign and legality; the FSM and wait counter stay in mccpu_control.

Verification
REQ-035 Reset held 3 cycles then released -> strobes 0 during reset; first cycle after release state=0, ir_wr=1, pc_wr=1.
REQ-036 op=6'h23 (lw), MEM_WAIT=2 -> states 0,1,2,3,3,3,4,0; reg_wr=1, wb_sel=1 only in state 4.
REQ-037 op=6'h2b (sw), MEM_WAIT=0 -> dmem_wena high for exactly one cycle in state 3, reg_wr never high.
REQ-038 op=6'h04 (beq) with zero=1 then zero=0 -> pc_wr=1, pc_src=1 in EXEC only in the first case; both return to FETCH after 3 cycles.
REQ-039 op=6'h03 (jal) -> in DECODE pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, wb_sel=2; op=6'h3f -> TRAP, illegal=1 held until reset.
REQ-040 Reset asserted in the last MEM cycle of sw -> dmem_wena=0, next state FETCH.
